// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetch-stage controller for the single-issue RISC-V core. It chooses the
// value the external program counter register loads each cycle (hold, PC+4,
// redirect target or trap vector), runs the instruction-memory req/ack
// handshake and hands fetched words to decode over a valid/ready pair.
// Redirects that arrive while a fetch is outstanding are drained: the memory
// request is kept stable until it acks, and the returned word is dropped.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   pc                          current PC from the program counter register
//   next_pc                     combinational value the PC register loads
//   imem_req/imem_addr          fetch request and address
//   imem_ack/imem_rdata         fetch completion and instruction word
//   if_valid/if_pc/if_instr     registered instruction handed to decode
//   if_ready                    decode accepts the instruction
//   redirect_valid/_target      taken branch/jump from execute
//   trap                        exception/interrupt redirect
//   misaligned                  one-cycle pulse for a misaligned redirect
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] drain_addr;

    logic redirect_active;
    logic redirect_mis;

    // Redirects are ignored in IDLE; a trap outranks any branch redirect,
    // so a simultaneous misaligned branch does not raise the flag.
    assign redirect_active = (state != IDLE) && (trap || redirect_valid);
    assign redirect_mis    = (state != IDLE) && !trap && redirect_valid &&
                             (redirect_target[1:0] != 2'b00);

    // While draining, the address of the abandoned fetch is kept on the bus
    // because the PC has already moved to the redirect target.
    assign imem_req  = !reset && ((state == REQ) || (state == DRAIN));
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        next_pc = pc;
        if (reset) begin
            next_pc = RESET_VECTOR;
        end else if (redirect_active) begin
            if (trap || redirect_mis)
                next_pc = TRAP_VECTOR;
            else
                next_pc = redirect_target;
        end else if ((state == REQ) && imem_ack) begin
            next_pc = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            drain_addr <= '0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect_mis;
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (redirect_active) begin
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            // Word for the old path arrived: drop it.
                            state <= REQ;
                        end else begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_active || if_ready) begin
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                DRAIN: begin
                    if_valid <= 1'b0;
                    if (imem_ack)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The bench owns the program counter
// register (pc <= next_pc) and a simple instruction memory whose word is a
// fixed function of the address; expected values are written out per cycle.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = 32'h1234_5678;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) pc <= next_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h0000_0013;
        return a ^ 32'h5A00_0003;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .misaligned      (misaligned)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=%0d expected=0", failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; trap = 1'b0;

        // Reset held 5 cycles; redirects must be ignored meanwhile.
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200; trap = 1'b1;
        #1;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_next_pc", next_pc, 32'h0);
        check_eq("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        redirect_valid = 1'b0; trap = 1'b0;

        // Release: IDLE cycle, then REQ at RESET_VECTOR.
        reset = 1'b0; imem_ack = 1'b1; if_ready = 1'b1;
        #1;
        check_eq("idle_req", {31'b0, imem_req}, 32'h0);
        check_eq("idle_next_pc", next_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("seq_req", {31'b0, imem_req}, 32'h1);
            check_eq("seq_addr", imem_addr, 32'(4 * i));
            check_eq("seq_next_pc", next_pc, 32'(4 * i + 4));
            tick();
            check_eq("seq_if_valid", {31'b0, if_valid}, 32'h1);
            check_eq("seq_if_pc", if_pc, 32'(4 * i));
            check_eq("seq_if_instr", if_instr, mem_word(32'(4 * i)));
            check_eq("seq_pc", pc, 32'(4 * i + 4));
            check_eq("seq_hold_req", {31'b0, imem_req}, 32'h0);
        end

        // Backpressure: this HOLD cycle plus three more with if_ready low.
        if_ready = 1'b0;
        repeat (3) begin
            tick();
            check_eq("bp_if_valid", {31'b0, if_valid}, 32'h1);
            check_eq("bp_if_pc", if_pc, 32'h0000_000C);
            check_eq("bp_if_instr", if_instr, 32'h0000_0013);
            check_eq("bp_req", {31'b0, imem_req}, 32'h0);
        end
        if_ready = 1'b1;
        #1;
        check_eq("bp_last_req", {31'b0, imem_req}, 32'h0);
        tick();
        check_eq("bp_resume_req", {31'b0, imem_req}, 32'h1);
        check_eq("bp_resume_addr", imem_addr, 32'h0000_0010);
        check_eq("bp_resume_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check_eq("f10_if_pc", if_pc, 32'h0000_0010);

        // Redirect from HOLD to 0x8 flushes the held instruction.
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0008;
        #1;
        check_eq("hold_redir_next_pc", next_pc, 32'h0000_0008);
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        #1;
        check_eq("hold_redir_flush", {31'b0, if_valid}, 32'h0);
        check_eq("hold_redir_pc", pc, 32'h0000_0008);
        check_eq("wait1_addr", imem_addr, 32'h0000_0008);
        check_eq("wait1_next_pc", next_pc, 32'h0000_0008);
        tick();
        check_eq("wait2_addr", imem_addr, 32'h0000_0008);
        redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        #1;
        check_eq("wait_redir_next_pc", next_pc, 32'h0000_0040);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("drain_pc", pc, 32'h0000_0040);
        check_eq("drain_req", {31'b0, imem_req}, 32'h1);
        check_eq("drain_addr", imem_addr, 32'h0000_0008);
        check_eq("drain_next_pc", next_pc, 32'h0000_0040);
        imem_ack = 1'b1;
        #1;
        check_eq("drain_ack_addr", imem_addr, 32'h0000_0008);
        tick();
        if_ready = 1'b1;
        #1;
        check_eq("drained_not_valid", {31'b0, if_valid}, 32'h0);
        check_eq("target_req", {31'b0, imem_req}, 32'h1);
        check_eq("target_addr", imem_addr, 32'h0000_0040);
        tick();
        check_eq("target_if_valid", {31'b0, if_valid}, 32'h1);
        check_eq("target_if_pc", if_pc, 32'h0000_0040);
        check_eq("target_if_instr", if_instr, mem_word(32'h0000_0040));

        // Misaligned redirect goes to the trap vector and pulses once.
        redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
        #1;
        check_eq("mis_next_pc", next_pc, 32'h0000_0100);
        check_eq("mis_pre_flag", {31'b0, misaligned}, 32'h0);
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        #1;
        check_eq("mis_pc", pc, 32'h0000_0100);
        check_eq("mis_flag", {31'b0, misaligned}, 32'h1);
        tick();
        check_eq("mis_flag_clear", {31'b0, misaligned}, 32'h0);
        check_eq("mis_hold_pc", pc, 32'h0000_0100);

        // Trap with aligned redirect and a same-cycle ack: data discarded.
        trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0080;
        imem_ack = 1'b1;
        #1;
        check_eq("trap_next_pc", next_pc, 32'h0000_0100);
        tick();
        trap = 1'b0; redirect_valid = 1'b0;
        #1;
        check_eq("trap_pc", pc, 32'h0000_0100);
        check_eq("trap_misaligned", {31'b0, misaligned}, 32'h0);
        check_eq("trap_discard", {31'b0, if_valid}, 32'h0);
        check_eq("trap_req_addr", imem_addr, 32'h0000_0100);
        tick();
        check_eq("trap_if_pc", if_pc, 32'h0000_0100);
        check_eq("trap_if_instr", if_instr, mem_word(32'h0000_0100));

        // Wrap-around at the top of the address space.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wrap_next_pc", next_pc, 32'h0000_0000);
        tick();
        check_eq("wrap_if_pc0", if_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc", pc, 32'h0000_0000);
        tick();
        check_eq("wrap_addr0", imem_addr, 32'h0000_0000);
        tick();
        check_eq("wrap_if_pc1", if_pc, 32'h0000_0000);

        // Reset while a fetch at 0x4 is waiting for its ack.
        imem_ack = 1'b0;
        tick();
        check_eq("mid_req", {31'b0, imem_req}, 32'h1);
        check_eq("mid_addr", imem_addr, 32'h0000_0004);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_next_pc", next_pc, 32'h0);
        tick();
        check_eq("mid_rst_valid", {31'b0, if_valid}, 32'h0);
        check_eq("mid_rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_if_pc", if_pc, 32'h0);
        reset = 1'b0; imem_ack = 1'b1;
        #1;
        check_eq("mid_idle_req", {31'b0, imem_req}, 32'h0);
        tick();
        check_eq("mid_first_req", {31'b0, imem_req}, 32'h1);
        check_eq("mid_first_addr", imem_addr, 32'h0);
        tick();
        check_eq("mid_first_if_pc", if_pc, 32'h0);
        check_eq("mid_first_instr", if_instr, mem_word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
